// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline control slice: hazard-controller FSM states
// and forwarding-mux selects. FORWARD_EN (optional) enables forwarding in
// pipeline_hazard_ctrl; these types are present in either build.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    DWAIT      = 2'd1,
    REDIR_PEND = 2'd2
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/hazard_perf_ctr.sv
// Saturating performance counter: counts cycles with inc=1, sticks at all-ones.
module hazard_perf_ctr #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count up on inc, hold once every bit is set.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Handles RAW/load-use hazards, redirects, I-miss and D-mem wait; a redirect
// seen during a D-mem wait is held in REDIR_PEND and applied once dhit returns.
// Optional macro FORWARD_EN: adds forwarding selects and reduces the data
// hazard to load-use only.
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic             ex_regwr,
  input  logic             ex_memrd,
  input  logic [REG_W-1:0] mem_wsel,
  input  logic             mem_regwr,
  input  logic             mem_redirect,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dreq,
`ifdef FORWARD_EN
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] wb_wsel,
  input  logic             wb_regwr,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
`endif
  output logic             pc_en,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             fl_ifid,
  output logic             fl_idex,
  output logic             fl_exmem,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redir_cnt
);

  hz_state_t state, state_nxt;
  logic      d_wait;
  logic      redirect;
  logic      data_hz;

  // Writer w collides with a source the ID instruction really reads; r0 never does.
  function automatic logic src_match(input logic [REG_W-1:0] w,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt,
                                     input logic use_rs,
                                     input logic use_rt);
    return (w != '0) && ((use_rs && (w == rs)) || (use_rt && (w == rt)));
  endfunction

`ifdef FORWARD_EN
  // MEM result wins over WB; r0 is never forwarded.
  function automatic fwd_sel_t fwd_pick(input logic [REG_W-1:0] src,
                                        input logic [REG_W-1:0] m_w,
                                        input logic m_wr,
                                        input logic [REG_W-1:0] w_w,
                                        input logic w_wr);
    if (m_wr && (m_w != '0) && (m_w == src)) return FWD_MEM;
    if (w_wr && (w_w != '0) && (w_w == src)) return FWD_WB;
    return FWD_RF;
  endfunction

  logic unused_fwd;
  assign unused_fwd = &{1'b0, ex_regwr};

  // Load-use is the only stall left once results can be forwarded.
  always_comb begin
    data_hz = ex_memrd && src_match(ex_wsel, id_rs, id_rt, id_use_rs, id_use_rt);
  end

  // Forwarding selects; forced to register-file path during reset.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (nRST) begin
      fwd_a = fwd_pick(ex_rs, mem_wsel, mem_regwr, wb_wsel, wb_regwr);
      fwd_b = fwd_pick(ex_rt, mem_wsel, mem_regwr, wb_wsel, wb_regwr);
    end
  end
`else
  logic unused_nofwd;
  assign unused_nofwd = &{1'b0, ex_memrd};

  // Without forwarding any pending write in EX or MEM to a used source stalls.
  always_comb begin
    data_hz = (ex_regwr  && src_match(ex_wsel,  id_rs, id_rt, id_use_rs, id_use_rt)) ||
              (mem_regwr && src_match(mem_wsel, id_rs, id_rt, id_use_rs, id_use_rt));
  end
`endif

  // Per-cycle priority decode: D-wait > redirect > data hazard > I-miss > run.
  // REDIR_PEND keeps the pipe frozen until dhit, then fires the stored redirect.
  always_comb begin
    d_wait   = ~dhit && (mem_dreq || (state == REDIR_PEND));
    redirect = ~d_wait && (mem_redirect || (state == REDIR_PEND));
    pc_en    = 1'b1;
    en_ifid  = 1'b1;
    en_idex  = 1'b1;
    en_exmem = 1'b1;
    en_memwb = 1'b1;
    fl_ifid  = 1'b0;
    fl_idex  = 1'b0;
    fl_exmem = 1'b0;
    if (!nRST) begin
      pc_en    = 1'b0;
      fl_ifid  = 1'b1;
      fl_idex  = 1'b1;
      fl_exmem = 1'b1;
    end else if (d_wait) begin
      pc_en    = 1'b0;
      en_ifid  = 1'b0;
      en_idex  = 1'b0;
      en_exmem = 1'b0;
      en_memwb = 1'b0;
    end else if (redirect) begin
      fl_ifid  = 1'b1;
      fl_idex  = (FLUSH_DEPTH >= 2);
      fl_exmem = (FLUSH_DEPTH >= 3);
    end else if (data_hz) begin
      pc_en   = 1'b0;
      en_ifid = 1'b0;
      fl_idex = 1'b1;
    end else if (!ihit) begin
      pc_en   = 1'b0;
      fl_ifid = 1'b1;
    end
  end

  // Next state: any non-waiting cycle returns to RUN (a pending redirect is consumed).
  always_comb begin
    state_nxt = RUN;
    if (d_wait) begin
      state_nxt = (mem_redirect || (state == REDIR_PEND)) ? REDIR_PEND : DWAIT;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= state_nxt;
  end

  hazard_perf_ctr #(.CNT_W(CNT_W)) u_stall_ctr (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (~pc_en),
    .cnt  (stall_cnt)
  );

  hazard_perf_ctr #(.CNT_W(CNT_W)) u_redir_ctr (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (redirect),
    .cnt  (redir_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (default build, FLUSH_DEPTH=2,
// CNT_W=4 so counter saturation is reachable).
module tb_pipeline_hazard_ctrl;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 4;

  localparam logic [3:0] EN_ALL  = 4'b1111;
  localparam logic [3:0] EN_HZ   = 4'b0111;
  localparam logic [3:0] EN_NONE = 4'b0000;
  localparam logic [2:0] FL_NONE = 3'b000;
  localparam logic [2:0] FL_RST  = 3'b111;
  localparam logic [2:0] FL_HZ   = 3'b010;
  localparam logic [2:0] FL_IMS  = 3'b100;
  localparam logic [2:0] FL_RED  = 3'b110;

  logic             CLK = 1'b0;
  logic             nRST;
  logic [REG_W-1:0] id_rs, id_rt, ex_wsel, mem_wsel;
  logic             id_use_rs, id_use_rt, ex_regwr, ex_memrd, mem_regwr;
  logic             mem_redirect, ihit, dhit, mem_dreq;
  logic             pc_en, en_ifid, en_idex, en_exmem, en_memwb;
  logic             fl_ifid, fl_idex, fl_exmem;
  logic [CNT_W-1:0] stall_cnt, redir_cnt;
`ifdef FORWARD_EN
  logic [REG_W-1:0] ex_rs = '0, ex_rt = '0, wb_wsel = '0;
  logic             wb_regwr = 1'b0;
  logic [1:0]       fwd_a, fwd_b;
`endif

  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .FLUSH_DEPTH(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_wsel(ex_wsel), .ex_regwr(ex_regwr), .ex_memrd(ex_memrd),
    .mem_wsel(mem_wsel), .mem_regwr(mem_regwr), .mem_redirect(mem_redirect),
    .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
`ifdef FORWARD_EN
    .ex_rs(ex_rs), .ex_rt(ex_rt), .wb_wsel(wb_wsel), .wb_regwr(wb_regwr),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
`endif
    .pc_en(pc_en), .en_ifid(en_ifid), .en_idex(en_idex), .en_exmem(en_exmem),
    .en_memwb(en_memwb), .fl_ifid(fl_ifid), .fl_idex(fl_idex), .fl_exmem(fl_exmem),
    .stall_cnt(stall_cnt), .redir_cnt(redir_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       nm;
    logic        pc;
    logic [3:0]  en;
    logic [2:0]  fl;
    int unsigned sc;
    int unsigned rc;
  } exp_t;

  exp_t q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic push_exp(input string nm, input logic pc, input logic [3:0] en,
                          input logic [2:0] fl, input int unsigned sc, input int unsigned rc);
    exp_t e;
    e.nm = nm; e.pc = pc; e.en = en; e.fl = fl; e.sc = sc; e.rc = rc;
    q.push_back(e);
  endtask

  // Advance to just after the next rising edge and return inputs to idle.
  task automatic cyc();
    @(posedge CLK);
    #1;
    id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_wsel = '0; ex_regwr = 1'b0; ex_memrd = 1'b0;
    mem_wsel = '0; mem_regwr = 1'b0; mem_redirect = 1'b0;
    ihit = 1'b1; dhit = 1'b1; mem_dreq = 1'b0;
  endtask

  // Monitor: every falling edge with a pending expectation, compare and pop.
  initial begin : monitor
    exp_t e;
    logic [7:0] act_c, exp_c;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        act_c = {pc_en, en_ifid, en_idex, en_exmem, en_memwb, fl_ifid, fl_idex, fl_exmem};
        exp_c = {e.pc, e.en, e.fl};
        checks++;
        if (act_c !== exp_c) begin
          errors++;
          $display("FAIL %s ctrl {pc,en4,fl3}: got %b want %b", e.nm, act_c, exp_c);
        end
        checks++;
        if ((stall_cnt !== CNT_W'(e.sc)) || (redir_cnt !== CNT_W'(e.rc))) begin
          errors++;
          $display("FAIL %s counters: got stall=%0d redir=%0d want stall=%0d redir=%0d",
                   e.nm, stall_cnt, redir_cnt, e.sc, e.rc);
        end
      end
    end
  end

  initial begin : stim
    nRST = 1'b0;
    cyc(); ihit = 1'b0; push_exp("reset_a", 0, EN_ALL, FL_RST, 0, 0);
    cyc(); mem_dreq = 1'b1; dhit = 1'b0; push_exp("reset_b", 0, EN_ALL, FL_RST, 0, 0);
    cyc(); nRST = 1'b1; push_exp("idle0", 1, EN_ALL, FL_NONE, 0, 0);

    cyc(); ex_memrd = 1'b1; ex_regwr = 1'b1; ex_wsel = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    push_exp("load_use", 0, EN_HZ, FL_HZ, 0, 0);
    cyc(); push_exp("after_lu", 1, EN_ALL, FL_NONE, 1, 0);

    cyc(); mem_regwr = 1'b1; mem_wsel = 5'd9; id_rt = 5'd9; id_use_rt = 1'b1;
    push_exp("mem_raw", 0, EN_HZ, FL_HZ, 1, 0);
    cyc(); mem_regwr = 1'b1; mem_wsel = 5'd9; id_rt = 5'd9;
    push_exp("rt_unused", 1, EN_ALL, FL_NONE, 2, 0);
    cyc(); ex_regwr = 1'b1; ex_wsel = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    push_exp("reg0", 1, EN_ALL, FL_NONE, 2, 0);
    cyc(); ex_regwr = 1'b1; ex_wsel = 5'd3; id_rt = 5'd3; id_use_rt = 1'b1;
    push_exp("ex_raw", 0, EN_HZ, FL_HZ, 2, 0);

    cyc(); ihit = 1'b0; push_exp("imiss", 0, EN_ALL, FL_IMS, 3, 0);
    cyc(); ihit = 1'b0; ex_regwr = 1'b1; ex_wsel = 5'd4; id_rs = 5'd4; id_use_rs = 1'b1;
    push_exp("hz_over_imiss", 0, EN_HZ, FL_HZ, 4, 0);
    cyc(); ihit = 1'b0; mem_redirect = 1'b1;
    ex_regwr = 1'b1; ex_wsel = 5'd4; id_rs = 5'd4; id_use_rs = 1'b1;
    push_exp("redir_over_all", 1, EN_ALL, FL_RED, 5, 0);
    cyc(); push_exp("after_redir", 1, EN_ALL, FL_NONE, 5, 1);

    // Redirect arriving during a D-mem wait is deferred.
    cyc(); mem_dreq = 1'b1; dhit = 1'b0; mem_redirect = 1'b1;
    push_exp("dw_redir_c1", 0, EN_NONE, FL_NONE, 5, 1);
    cyc(); mem_dreq = 1'b1; dhit = 1'b0; mem_redirect = 1'b1;
    push_exp("dw_redir_c2", 0, EN_NONE, FL_NONE, 6, 1);
    cyc(); mem_dreq = 1'b1; dhit = 1'b0;
    push_exp("dw_redir_c3", 0, EN_NONE, FL_NONE, 7, 1);
    cyc(); mem_dreq = 1'b1; ihit = 1'b0;
    push_exp("pend_apply", 1, EN_ALL, FL_RED, 8, 1);
    cyc(); push_exp("pend_once_a", 1, EN_ALL, FL_NONE, 8, 2);
    cyc(); push_exp("pend_once_b", 1, EN_ALL, FL_NONE, 8, 2);

    // Plain D-wait, then the release cycle falls through to the hazard check.
    cyc(); mem_dreq = 1'b1; dhit = 1'b0; push_exp("dwait", 0, EN_NONE, FL_NONE, 8, 2);
    cyc(); mem_dreq = 1'b1; mem_regwr = 1'b1; mem_wsel = 5'd7; id_rs = 5'd7; id_use_rs = 1'b1;
    push_exp("dwait_exit_hz", 0, EN_HZ, FL_HZ, 9, 2);
    cyc(); push_exp("idle1", 1, EN_ALL, FL_NONE, 10, 2);
    cyc(); mem_dreq = 1'b1; mem_redirect = 1'b1;
    push_exp("redir_dhit", 1, EN_ALL, FL_RED, 10, 2);
    cyc(); push_exp("idle2", 1, EN_ALL, FL_NONE, 10, 3);

    // Stall counter saturates at 15 with CNT_W=4.
    for (int i = 0; i < 20; i++) begin
      cyc(); ihit = 1'b0;
      push_exp($sformatf("sat%0d", i), 0, EN_ALL, FL_IMS, ((10 + i) > 15) ? 15 : (10 + i), 3);
    end
    cyc(); push_exp("sat_hold", 1, EN_ALL, FL_NONE, 15, 3);

    // Reset while a redirect is pending drops it.
    cyc(); mem_dreq = 1'b1; dhit = 1'b0; mem_redirect = 1'b1;
    push_exp("pend_set", 0, EN_NONE, FL_NONE, 15, 3);
    cyc(); nRST = 1'b0; mem_dreq = 1'b1; dhit = 1'b0; mem_redirect = 1'b1;
    push_exp("rst_mid_pend", 0, EN_ALL, FL_RST, 0, 0);
    cyc(); nRST = 1'b1; push_exp("post_rst_a", 1, EN_ALL, FL_NONE, 0, 0);
    cyc(); push_exp("post_rst_b", 1, EN_ALL, FL_NONE, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
